alu_issue_stage: RTL and testbench

Execute-stage front end of the single-issue core. It accepts decoded RV32I fields from the decode stage over a valid/ready handshake and translates opcode/funct3/funct7 into the 4-bit ALU operation code. It selects the A/B operands, drives the combinational ALU, and registers the result, write-back control and branch redirect toward the memory stage. It is the producer side of the ALU `op`/`A`/`B` interface, and owns the decoder that the ALU itself does not contain.

---
 rtl/alu_issue_stage_pkg.sv | 61 ++++++
 rtl/alu_issue_stage_if.sv | 50 +++++
 rtl/alu.sv | 42 ++++
 rtl/alu_op_decode.sv | 78 +++++++
 rtl/alu_issue_stage.sv | 160 ++++++++++++++++
 tb/tb_alu_issue_stage.sv | 309 ++++++++++++++++++++++++++++++
 6 files changed

// File: rtl/alu_issue_stage_pkg.sv
// ============================================================================
// alu_issue_stage_pkg : ALU op codes, RV32I opcode/funct3 constants, operand
//                       select encodings shared by the issue stage.
// Revision: 1.0
// ============================================================================
`default_nettype none

package alu_issue_stage_pkg;

  // Compare-family codes share the x01x pattern; SUB reuses the EQ code.
  typedef enum logic [3:0] {
    ALU_ADD = 4'b0000,
    ALU_EQ  = 4'b0010,
    ALU_NE  = 4'b0011,
    ALU_AND = 4'b0100,
    ALU_OR  = 4'b0101,
    ALU_XOR = 4'b0110,
    ALU_SLL = 4'b0111,
    ALU_SRL = 4'b1000,
    ALU_SRA = 4'b1001,
    ALU_LT  = 4'b1010,
    ALU_GE  = 4'b1011
  } alu_op_e;

  localparam alu_op_e ALU_SUB = ALU_EQ;

  typedef enum logic [1:0] {
    ASEL_RS1  = 2'b00,
    ASEL_ZERO = 2'b01,
    ASEL_PC   = 2'b10
  } asel_e;

  typedef enum logic {
    BSEL_RS2 = 1'b0,
    BSEL_IMM = 1'b1
  } bsel_e;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

  localparam logic [2:0] F3_ADD = 3'b000;
  localparam logic [2:0] F3_SLL = 3'b001;
  localparam logic [2:0] F3_XOR = 3'b100;
  localparam logic [2:0] F3_SR  = 3'b101;
  localparam logic [2:0] F3_OR  = 3'b110;
  localparam logic [2:0] F3_AND = 3'b111;
  localparam logic [2:0] F3_BEQ = 3'b000;
  localparam logic [2:0] F3_BNE = 3'b001;
  localparam logic [2:0] F3_BLT = 3'b100;
  localparam logic [2:0] F3_BGE = 3'b101;

  function automatic logic is_compare(input alu_op_e op);
    return (op[2:1] == 2'b01);
  endfunction

endpackage

`default_nettype wire

// File: rtl/alu_issue_stage_if.sv
// ============================================================================
// alu_issue_stage_if : decode-side and memory-side handshake bundle of the
//                      ALU issue stage. slave = issue stage, master = peers.
// Revision: 1.0
// ============================================================================
`default_nettype none

interface alu_issue_stage_if #(
  parameter int XLEN = 32
);

  logic            in_valid;
  logic            in_ready;
  logic [6:0]      in_opcode;
  logic [2:0]      in_funct3;
  logic            in_funct7b5;
  logic [4:0]      in_rd;
  logic [4:0]      in_rs1;
  logic [4:0]      in_rs2;
  logic [XLEN-1:0] in_rs1_val;
  logic [XLEN-1:0] in_rs2_val;
  logic [XLEN-1:0] in_imm;
  logic [XLEN-1:0] in_pc;

  logic            out_valid;
  logic            out_ready;
  logic [4:0]      out_rd;
  logic [XLEN-1:0] out_result;
  logic            out_wb_en;
  logic            out_illegal;
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_pc;

  modport slave (
    input  in_valid, in_opcode, in_funct3, in_funct7b5, in_rd, in_rs1, in_rs2,
           in_rs1_val, in_rs2_val, in_imm, in_pc, out_ready,
    output in_ready, out_valid, out_rd, out_result, out_wb_en, out_illegal,
           redirect_valid, redirect_pc
  );

  modport master (
    output in_valid, in_opcode, in_funct3, in_funct7b5, in_rd, in_rs1, in_rs2,
           in_rs1_val, in_rs2_val, in_imm, in_pc, out_ready,
    input  in_ready, out_valid, out_rd, out_result, out_wb_en, out_illegal,
           redirect_valid, redirect_pc
  );

endinterface

`default_nettype wire

// File: rtl/alu.sv
// ============================================================================
// alu : combinational ALU driven by the 4-bit op code; compare-family ops
//       return A - B.
// Revision: 1.0
// ============================================================================
`default_nettype none

module alu
  import alu_issue_stage_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  alu_op_e         op_i,
  input  logic [XLEN-1:0] a_i,
  input  logic [XLEN-1:0] b_i,
  output logic [XLEN-1:0] c_o
);

  logic [4:0] w_shamt;
  assign w_shamt = b_i[4:0];

  always_comb begin
    c_o = '0;
    if (is_compare(op_i)) begin
      c_o = a_i - b_i;
    end else begin
      case (op_i)
        ALU_ADD: c_o = a_i + b_i;
        ALU_AND: c_o = a_i & b_i;
        ALU_OR:  c_o = a_i | b_i;
        ALU_XOR: c_o = a_i ^ b_i;
        ALU_SLL: c_o = a_i << w_shamt;
        ALU_SRL: c_o = a_i >> w_shamt;
        ALU_SRA: c_o = $signed(a_i) >>> w_shamt;
        default: c_o = '0;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: rtl/alu_op_decode.sv
// ============================================================================
// alu_op_decode : maps opcode/funct3/funct7b5 to ALU op, operand selects,
//                 write-back, branch and illegal flags (combinational).
// Revision: 1.0
// ============================================================================
`default_nettype none

module alu_op_decode
  import alu_issue_stage_pkg::*;
(
  input  logic [6:0] opcode_i,
  input  logic [2:0] funct3_i,
  input  logic       funct7b5_i,
  output alu_op_e    op_o,
  output asel_e      a_sel_o,
  output bsel_e      b_sel_o,
  output logic       wb_o,
  output logic       branch_o,
  output logic       illegal_o
);

  always_comb begin
    op_o      = ALU_ADD;
    a_sel_o   = ASEL_RS1;
    b_sel_o   = BSEL_RS2;
    wb_o      = 1'b0;
    branch_o  = 1'b0;
    illegal_o = 1'b0;
    case (opcode_i)
      OPC_OP, OPC_OPIMM: begin
        if (opcode_i == OPC_OPIMM) b_sel_o = BSEL_IMM;
        wb_o = 1'b1;
        case (funct3_i)
          // funct7b5 means SUB only for register-register ADD
          F3_ADD: if (funct7b5_i && (opcode_i == OPC_OP)) op_o = ALU_SUB;
                  else op_o = ALU_ADD;
          F3_SLL: op_o = ALU_SLL;
          F3_XOR: op_o = ALU_XOR;
          F3_SR:  if (funct7b5_i) op_o = ALU_SRA;
                  else op_o = ALU_SRL;
          F3_OR:  op_o = ALU_OR;
          F3_AND: op_o = ALU_AND;
          default: begin
            wb_o      = 1'b0;
            illegal_o = 1'b1;
          end
        endcase
      end
      OPC_LUI: begin
        a_sel_o = ASEL_ZERO;
        b_sel_o = BSEL_IMM;
        wb_o    = 1'b1;
      end
      OPC_AUIPC: begin
        a_sel_o = ASEL_PC;
        b_sel_o = BSEL_IMM;
        wb_o    = 1'b1;
      end
      OPC_BRANCH: begin
        branch_o = 1'b1;
        case (funct3_i)
          F3_BEQ: op_o = ALU_EQ;
          F3_BNE: op_o = ALU_NE;
          F3_BLT: op_o = ALU_LT;
          F3_BGE: op_o = ALU_GE;
          default: begin
            branch_o  = 1'b0;
            illegal_o = 1'b1;
          end
        endcase
      end
      default: illegal_o = 1'b1;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/alu_issue_stage.sv
// ============================================================================
// alu_issue_stage : execute-stage front end - decode, operand select, ALU,
//                   branch resolution and the output pipeline register.
// Optional: ALU_ISSUE_FWD_EN enables result forwarding from the output reg.
// Revision: 1.0
// ============================================================================
`default_nettype none

module alu_issue_stage
  import alu_issue_stage_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  alu_issue_stage_if.slave  bus
);

  alu_op_e         w_op;
  asel_e           w_a_sel;
  bsel_e           w_b_sel;
  logic            w_wb;
  logic            w_branch;
  logic            w_illegal;
  logic            w_in_ready;
  logic            w_accept;
  logic            w_taken;
  logic [XLEN-1:0] w_rs1;
  logic [XLEN-1:0] w_rs2;
  logic [XLEN-1:0] w_a;
  logic [XLEN-1:0] w_b;
  logic [XLEN-1:0] w_c;
  logic [XLEN-1:0] w_target;

  logic            out_valid_q,      out_valid_d;
  logic [4:0]      out_rd_q,         out_rd_d;
  logic [XLEN-1:0] out_result_q,     out_result_d;
  logic            out_wb_en_q,      out_wb_en_d;
  logic            out_illegal_q,    out_illegal_d;
  logic            redirect_valid_q, redirect_valid_d;
  logic [XLEN-1:0] redirect_pc_q,    redirect_pc_d;

  assign w_in_ready  = !out_valid_q || bus.out_ready;
  assign w_accept    = bus.in_valid && w_in_ready && !flush;
  assign bus.in_ready = w_in_ready;

  alu_op_decode u_decode (
    .opcode_i   (bus.in_opcode),
    .funct3_i   (bus.in_funct3),
    .funct7b5_i (bus.in_funct7b5),
    .op_o       (w_op),
    .a_sel_o    (w_a_sel),
    .b_sel_o    (w_b_sel),
    .wb_o       (w_wb),
    .branch_o   (w_branch),
    .illegal_o  (w_illegal)
  );

`ifdef ALU_ISSUE_FWD_EN
  // out_wb_en_q is already clear for rd = 0, but x0 is excluded explicitly
  logic w_fwd_src;
  assign w_fwd_src = out_valid_q && out_wb_en_q;
  assign w_rs1 = (w_fwd_src && (bus.in_rs1 != 5'd0) && (bus.in_rs1 == out_rd_q))
               ? out_result_q : bus.in_rs1_val;
  assign w_rs2 = (w_fwd_src && (bus.in_rs2 != 5'd0) && (bus.in_rs2 == out_rd_q))
               ? out_result_q : bus.in_rs2_val;
`else
  logic w_unused_idx;
  assign w_unused_idx = ^{bus.in_rs1, bus.in_rs2};
  assign w_rs1 = bus.in_rs1_val;
  assign w_rs2 = bus.in_rs2_val;
`endif

  always_comb begin
    case (w_a_sel)
      ASEL_ZERO: w_a = '0;
      ASEL_PC:   w_a = bus.in_pc;
      default:   w_a = w_rs1;
    endcase
    w_b = (w_b_sel == BSEL_IMM) ? bus.in_imm : w_rs2;
  end

  alu #(.XLEN(XLEN)) u_alu (
    .op_i (w_op),
    .a_i  (w_a),
    .b_i  (w_b),
    .c_o  (w_c)
  );

  always_comb begin
    w_taken = 1'b0;
    if (w_branch) begin
      case (w_op)
        ALU_EQ:  w_taken = (w_a == w_b);
        ALU_NE:  w_taken = (w_a != w_b);
        ALU_LT:  w_taken = ($signed(w_a) <  $signed(w_b));
        ALU_GE:  w_taken = ($signed(w_a) >= $signed(w_b));
        default: w_taken = 1'b0;
      endcase
    end
  end

  assign w_target = bus.in_pc + bus.in_imm;

  // redirect defaults low so it only pulses on the load edge
  always_comb begin
    out_valid_d      = out_valid_q;
    out_rd_d         = out_rd_q;
    out_result_d     = out_result_q;
    out_wb_en_d      = out_wb_en_q;
    out_illegal_d    = out_illegal_q;
    redirect_pc_d    = redirect_pc_q;
    redirect_valid_d = 1'b0;
    if (flush) begin
      out_valid_d = 1'b0;
    end else if (w_accept) begin
      out_valid_d      = 1'b1;
      out_rd_d         = bus.in_rd;
      out_result_d     = w_illegal ? '0 : w_c;
      out_wb_en_d      = w_wb && (bus.in_rd != 5'd0);
      out_illegal_d    = w_illegal;
      redirect_valid_d = w_taken;
      redirect_pc_d    = w_target;
    end else if (bus.out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q      <= 1'b0;
      out_rd_q         <= 5'd0;
      out_result_q     <= '0;
      out_wb_en_q      <= 1'b0;
      out_illegal_q    <= 1'b0;
      redirect_valid_q <= 1'b0;
      redirect_pc_q    <= '0;
    end else begin
      out_valid_q      <= out_valid_d;
      out_rd_q         <= out_rd_d;
      out_result_q     <= out_result_d;
      out_wb_en_q      <= out_wb_en_d;
      out_illegal_q    <= out_illegal_d;
      redirect_valid_q <= redirect_valid_d;
      redirect_pc_q    <= redirect_pc_d;
    end
  end

  assign bus.out_valid      = out_valid_q;
  assign bus.out_rd         = out_rd_q;
  assign bus.out_result     = out_result_q;
  assign bus.out_wb_en      = out_wb_en_q;
  assign bus.out_illegal    = out_illegal_q;
  assign bus.redirect_valid = redirect_valid_q;
  assign bus.redirect_pc    = redirect_pc_q;

endmodule

`default_nettype wire

// File: tb/tb_alu_issue_stage.sv
// ============================================================================
// tb_alu_issue_stage : directed checks plus randomized traffic compared every
//                      cycle against an instruction-level reference model.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_alu_issue_stage;

  localparam logic [6:0] T_OP     = 7'b0110011;
  localparam logic [6:0] T_OPIMM  = 7'b0010011;
  localparam logic [6:0] T_BRANCH = 7'b1100011;
  localparam logic [6:0] T_LUI    = 7'b0110111;
  localparam logic [6:0] T_AUIPC  = 7'b0010111;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic flush = 1'b0;

  alu_issue_stage_if #(.XLEN(32)) bus ();

  alu_issue_stage #(.XLEN(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (flush),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  typedef struct packed {
    logic [31:0] res;
    logic        wb;
    logic        ill;
    logic        taken;
    logic [31:0] tgt;
  } exp_t;

  // Instruction semantics straight from the ISA description
  function automatic exp_t calc(input logic [6:0] opc, input logic [2:0] f3, input logic f7,
                                input logic [4:0] rd, input logic [31:0] a_in,
                                input logic [31:0] b_in, input logic [31:0] imm,
                                input logic [31:0] pc);
    exp_t e;
    logic [31:0] a;
    logic [31:0] b;
    e = '0;
    a = a_in;
    b = b_in;
    case (opc)
      T_OP, T_OPIMM: begin
        if (opc == T_OPIMM) b = imm;
        e.wb = 1'b1;
        case (f3)
          3'd0: e.res = (opc == T_OP && f7) ? a - b : a + b;
          3'd1: e.res = a << b[4:0];
          3'd4: e.res = a ^ b;
          3'd5: begin
            if (f7) e.res = $signed(a) >>> b[4:0];
            else    e.res = a >> b[4:0];
          end
          3'd6: e.res = a | b;
          3'd7: e.res = a & b;
          default: e.ill = 1'b1;
        endcase
      end
      T_LUI: begin e.res = imm; e.wb = 1'b1; end
      T_AUIPC: begin e.res = pc + imm; e.wb = 1'b1; end
      T_BRANCH: begin
        case (f3)
          3'd0: e.taken = (a == b);
          3'd1: e.taken = (a != b);
          3'd4: e.taken = ($signed(a) < $signed(b));
          3'd5: e.taken = ($signed(a) >= $signed(b));
          default: e.ill = 1'b1;
        endcase
        e.res = a - b;
      end
      default: e.ill = 1'b1;
    endcase
    if (e.ill) begin
      e.res   = '0;
      e.wb    = 1'b0;
      e.taken = 1'b0;
    end
    if (rd == 5'd0) e.wb = 1'b0;
    e.tgt = pc + imm;
    return e;
  endfunction

  logic        m_valid, m_wb, m_ill, m_rv;
  logic [4:0]  m_rd;
  logic [31:0] m_res, m_tgt;
  logic [31:0] a_eff, b_eff;
  exp_t        m_next;

  always_comb begin
    a_eff = bus.in_rs1_val;
    b_eff = bus.in_rs2_val;
`ifdef ALU_ISSUE_FWD_EN
    if (m_valid && m_wb && bus.in_rs1 != 5'd0 && bus.in_rs1 == m_rd) a_eff = m_res;
    if (m_valid && m_wb && bus.in_rs2 != 5'd0 && bus.in_rs2 == m_rd) b_eff = m_res;
`endif
    m_next = calc(bus.in_opcode, bus.in_funct3, bus.in_funct7b5, bus.in_rd,
                  a_eff, b_eff, bus.in_imm, bus.in_pc);
  end

  // One-entry output slot: retire on ready, replace on accept, drop on flush
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_valid <= 1'b0; m_rv <= 1'b0; m_rd <= 5'd0; m_res <= '0;
      m_wb <= 1'b0; m_ill <= 1'b0; m_tgt <= '0;
    end else if (flush) begin
      m_valid <= 1'b0;
      m_rv    <= 1'b0;
    end else if (bus.in_valid && (!m_valid || bus.out_ready)) begin
      m_valid <= 1'b1;
      m_rd    <= bus.in_rd;
      m_res   <= m_next.res;
      m_wb    <= m_next.wb;
      m_ill   <= m_next.ill;
      m_rv    <= m_next.taken;
      m_tgt   <= m_next.tgt;
    end else begin
      m_rv <= 1'b0;
      if (bus.out_ready) m_valid <= 1'b0;
    end
  end

  always @(negedge clk) begin
    chk("in_ready", 32'(bus.in_ready), 32'(!m_valid || bus.out_ready));
    chk("out_valid", 32'(bus.out_valid), 32'(m_valid));
    chk("redirect_valid", 32'(bus.redirect_valid), 32'(m_rv));
    if (m_valid) begin
      chk("out_rd", 32'(bus.out_rd), 32'(m_rd));
      chk("out_result", bus.out_result, m_res);
      chk("out_wb_en", 32'(bus.out_wb_en), 32'(m_wb));
      chk("out_illegal", 32'(bus.out_illegal), 32'(m_ill));
      chk("redirect_pc", bus.redirect_pc, m_tgt);
    end
  end

  task automatic drive(input logic [6:0] opc, input logic [2:0] f3, input logic f7,
                       input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                       input logic [31:0] v1, input logic [31:0] v2,
                       input logic [31:0] imm, input logic [31:0] pc);
    bus.in_valid = 1'b1; bus.in_opcode = opc; bus.in_funct3 = f3; bus.in_funct7b5 = f7;
    bus.in_rd = rd; bus.in_rs1 = rs1; bus.in_rs2 = rs2;
    bus.in_rs1_val = v1; bus.in_rs2_val = v2; bus.in_imm = imm; bus.in_pc = pc;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] rval();
    case ($urandom_range(0, 7))
      0, 1: return 32'($urandom_range(0, 40));
      2:    return 32'h8000_0000;
      3:    return 32'hFFFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  logic [6:0] r_opc;

  initial begin
    drive(T_OP, 3'd0, 1'b0, 5'd0, 5'd0, 5'd0, '0, '0, '0, '0);
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst out_wb_en", 32'(bus.out_wb_en), 32'd0);
    chk("rst out_illegal", 32'(bus.out_illegal), 32'd0);
    chk("rst redirect_valid", 32'(bus.redirect_valid), 32'd0);
    chk("rst out_rd", 32'(bus.out_rd), 32'd0);
    chk("rst out_result", bus.out_result, 32'd0);
    chk("rst redirect_pc", bus.redirect_pc, 32'd0);
    rst_n = 1'b1;

    drive(T_OP, 3'd0, 1'b0, 5'd3, 5'd1, 5'd2, 32'd7, 32'd5, '0, '0);
    step();
    chk("add valid", 32'(bus.out_valid), 32'd1);
    chk("add result", bus.out_result, 32'd12);
    chk("add rd", 32'(bus.out_rd), 32'd3);
    chk("add wb", 32'(bus.out_wb_en), 32'd1);

    drive(T_OPIMM, 3'd5, 1'b1, 5'd4, 5'd1, 5'd0, 32'h8000_0000, '0, 32'd4, '0);
    step();
    chk("srai result", bus.out_result, 32'hF800_0000);
    drive(T_OPIMM, 3'd5, 1'b0, 5'd4, 5'd1, 5'd0, 32'h8000_0000, '0, 32'd4, '0);
    step();
    chk("srli result", bus.out_result, 32'h0800_0000);

    drive(T_BRANCH, 3'd4, 1'b0, 5'd7, 5'd1, 5'd2, 32'hFFFF_FFFF, 32'd1, 32'h20, 32'h100);
    step();
    bus.in_valid = 1'b0;
    chk("blt redirect", 32'(bus.redirect_valid), 32'd1);
    chk("blt target", bus.redirect_pc, 32'h120);
    chk("blt wb", 32'(bus.out_wb_en), 32'd0);
    step();
    chk("blt pulse end", 32'(bus.redirect_valid), 32'd0);
    drive(T_BRANCH, 3'd5, 1'b0, 5'd7, 5'd1, 5'd2, 32'hFFFF_FFFF, 32'd1, 32'h20, 32'h100);
    step();
    bus.in_valid = 1'b0;
    chk("bge valid", 32'(bus.out_valid), 32'd1);
    chk("bge redirect", 32'(bus.redirect_valid), 32'd0);
    step();

    bus.out_ready = 1'b0;
    drive(T_BRANCH, 3'd0, 1'b0, 5'd0, 5'd1, 5'd2, 32'd5, 32'd5, 32'h40, 32'h200);
    step();
    chk("stall c1 redirect", 32'(bus.redirect_valid), 32'd1);
    drive(T_OPIMM, 3'd0, 1'b0, 5'd9, 5'd1, 5'd0, 32'd100, '0, 32'd1, '0);
    #1;
    chk("stall in_ready", 32'(bus.in_ready), 32'd0);
    for (int c = 2; c <= 3; c++) begin
      step();
      chk("stall redirect", 32'(bus.redirect_valid), 32'd0);
      chk("stall valid", 32'(bus.out_valid), 32'd1);
      chk("stall target", bus.redirect_pc, 32'h240);
      chk("stall result", bus.out_result, 32'd0);
    end
    bus.out_ready = 1'b1;
    #1;
    chk("unstall in_ready", 32'(bus.in_ready), 32'd1);
    step();
    bus.in_valid = 1'b0;
    chk("queued result", bus.out_result, 32'd101);
    chk("queued rd", 32'(bus.out_rd), 32'd9);

    bus.out_ready = 1'b0;
    drive(T_OP, 3'd0, 1'b0, 5'd10, 5'd1, 5'd2, 32'd1, 32'd1, '0, '0);
    flush = 1'b1;
    #1;
    chk("flush in_ready", 32'(bus.in_ready), 32'd0);
    step();
    flush = 1'b0;
    bus.in_valid = 1'b0;
    chk("flush valid", 32'(bus.out_valid), 32'd0);
    step();
    chk("flush not consumed", 32'(bus.out_valid), 32'd0);

    bus.out_ready = 1'b1;
    drive(T_OPIMM, 3'd0, 1'b0, 5'd5, 5'd0, 5'd0, 32'd0, '0, 32'd10, '0);
    step();
    chk("addi x5", bus.out_result, 32'd10);
    drive(T_OP, 3'd0, 1'b0, 5'd6, 5'd5, 5'd5, 32'd0, 32'd0, '0, '0);
    step();
    bus.in_valid = 1'b0;
`ifdef ALU_ISSUE_FWD_EN
    chk("fwd add", bus.out_result, 32'd20);
`else
    chk("nofwd add", bus.out_result, 32'd0);
`endif
    step();

    drive(T_LUI, 3'd0, 1'b0, 5'd8, 5'd0, 5'd0, '0, '0, 32'h1234_5000, '0);
    step();
    bus.in_valid = 1'b0;
    chk("lui result", bus.out_result, 32'h1234_5000);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async rst valid", 32'(bus.out_valid), 32'd0);
    chk("async rst result", bus.out_result, 32'd0);
    chk("async rst rd", 32'(bus.out_rd), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    step();

    for (int i = 0; i < 3000; i++) begin
      case ($urandom_range(0, 10))
        0, 1, 2: r_opc = T_OP;
        3, 4, 5: r_opc = T_OPIMM;
        6:       r_opc = T_LUI;
        7:       r_opc = T_AUIPC;
        8, 9:    r_opc = T_BRANCH;
        default: r_opc = 7'($urandom);
      endcase
      drive(r_opc, 3'($urandom), 1'($urandom), 5'($urandom_range(0, 7)),
            5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
            rval(), rval(), rval(), rval());
      bus.in_valid  = ($urandom_range(0, 3) != 0);
      bus.out_ready = ($urandom_range(0, 3) != 0);
      flush         = ($urandom_range(0, 15) == 0);
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
